// File: rtl/calculator_pkg.sv
// Shared calculator types and constants.
// Holds the BCD digit type, the reverse double-dabble adjust constants and the
// state type of the BCD-to-binary sequencer. No ports; imported by the
// converter and its digit-adjust sub-module.
package calculator_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
   localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;
   localparam bcd_digit_t BCD_ADJ_VAL    = 4'd3;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      NEG
   } b2b_state_t;

   // A packed nibble that is not a legal decimal digit.
   function automatic logic bcd_digit_invalid(input bcd_digit_t d);
      return d > BCD_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction.
// Ports:
//   digit_in  - BCD digit after the right shift
//   digit_out - digit_in minus 3 when digit_in >= 8, else digit_in unchanged
module bcd_digit_adjust
   import calculator_pkg::*;
(
   input  bcd_digit_t digit_in,
   output bcd_digit_t digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= BCD_ADJ_THRESH) begin
         digit_out = digit_in - BCD_ADJ_VAL;
      end
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one
// shift/adjust iteration per clock).
// Ports:
//   clk      - system clock (clk_50 domain)
//   reset    - asynchronous active-high reset
//   start    - conversion request, only honoured while idle
//   bcd      - packed BCD operand, digit 0 in [3:0], sampled on the accepting edge
//   bcd_neg  - sign of the operand (only when BCD_SIGN_EN is defined)
//   busy     - conversion in progress
//   done     - one-cycle pulse, binary/error/overflow valid
//   binary   - converted value, held until the next accepted start
//   error    - a digit was >9 on the accepted start
//   overflow - result does not fit in BITS (or negative magnitude > 2^(BITS-1))
// Optional feature macro: BCD_SIGN_EN (adds bcd_neg and the NEG state).
module bcd_to_bin_seq
   import calculator_pkg::*;
#(
   parameter int unsigned BITS       = 32,
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] bcd,
`ifdef BCD_SIGN_EN
   input  logic                    bcd_neg,
`endif
   output logic                    busy,
   output logic                    done,
   output logic [BITS-1:0]         binary,
   output logic                    error,
   output logic                    overflow
);

   localparam int unsigned W  = 4 * NUM_DIGITS;
   localparam int unsigned CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(W - 1);

   b2b_state_t      state;
   logic [W-1:0]    bcd_reg;
   logic [W-1:0]    bin_reg;
   logic [CW-1:0]   count;
`ifdef BCD_SIGN_EN
   localparam logic [BITS-1:0] NEG_LIMIT = {1'b1, {(BITS-1){1'b0}}};
   logic            neg_reg;
`endif

   logic [2*W-1:0]  shifted;
   logic [W-1:0]    bcd_sh;
   logic [W-1:0]    bin_sh;
   logic [W-1:0]    bcd_adj;
   logic [BITS-1:0] bin_fit;
   logic            bin_hi;
   logic            bcd_bad;

   // One iteration: shift the joint register right, then correct each digit.
   always_comb begin
      shifted = {bcd_reg, bin_reg} >> 1;
      bcd_sh  = shifted[2*W-1:W];
      bin_sh  = shifted[W-1:0];
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_in  (bcd_sh[4*g +: 4]),
         .digit_out (bcd_adj[4*g +: 4])
      );
   end

   // The cast truncates or zero-extends to the result width.
   assign bin_fit = BITS'(bin_sh);

   if (BITS >= W) begin : g_no_hi
      assign bin_hi = 1'b0;
   end else begin : g_hi
      assign bin_hi = |bin_sh[W-1:BITS];
   end

   always_comb begin
      bcd_bad = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_digit_invalid(bcd[4*i +: 4])) begin
            bcd_bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bcd_reg  <= '0;
         bin_reg  <= '0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         binary   <= '0;
         error    <= 1'b0;
         overflow <= 1'b0;
`ifdef BCD_SIGN_EN
         neg_reg  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_reg <= bcd;
                  bin_reg <= '0;
                  count   <= '0;
`ifdef BCD_SIGN_EN
                  neg_reg <= bcd_neg;
`endif
                  if (bcd_bad) begin
                     // Invalid operand: report immediately, no iterations.
                     error    <= 1'b1;
                     overflow <= 1'b0;
                     binary   <= '0;
                     done     <= 1'b1;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                     error <= 1'b0;
                  end
               end
            end

            SHIFT: begin
               bcd_reg <= bcd_adj;
               bin_reg <= bin_sh;
               // Stops at W at the most, since the state leaves SHIFT there.
               count   <= count + 1'b1;
               if (count == LAST_COUNT) begin
                  binary   <= bin_fit;
                  overflow <= bin_hi;
`ifdef BCD_SIGN_EN
                  if (neg_reg) begin
                     state <= NEG;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
`else
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
               end
            end

`ifdef BCD_SIGN_EN
            NEG: begin
               // Negating zero gives zero, so negative zero needs no special case.
               binary   <= ~binary + 1'b1;
               overflow <= overflow | (binary > NEG_LIMIT);
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
            end
`endif

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: a 32-bit-result instance and a
// 16-bit-result instance. Stimulus pushes expected results (with the cycle
// in which done must appear); monitors pop and compare on every done pulse.
module tb_bcd_to_bin_seq;

   typedef struct {
      logic [31:0] bin;
      logic        err;
      logic        ovf;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] bcd = '0;
   logic        busy, done, error, overflow;
   logic [31:0] binary;
`ifdef BCD_SIGN_EN
   logic        bcd_neg = 1'b0;
`endif

   logic        start16 = 1'b0;
   logic [31:0] bcd16 = '0;
   logic        busy16, done16, error16, overflow16;
   logic [15:0] binary16;
`ifdef BCD_SIGN_EN
   logic        bcd_neg16 = 1'b0;
`endif

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd_to_bin_seq #(.BITS(32), .NUM_DIGITS(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bcd      (bcd),
`ifdef BCD_SIGN_EN
      .bcd_neg  (bcd_neg),
`endif
      .busy     (busy),
      .done     (done),
      .binary   (binary),
      .error    (error),
      .overflow (overflow)
   );

   bcd_to_bin_seq #(.BITS(16), .NUM_DIGITS(8)) dut16 (
      .clk      (clk),
      .reset    (reset),
      .start    (start16),
      .bcd      (bcd16),
`ifdef BCD_SIGN_EN
      .bcd_neg  (bcd_neg16),
`endif
      .busy     (busy16),
      .done     (done16),
      .binary   (binary16),
      .error    (error16),
      .overflow (overflow16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_unexpected(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: done pulse with no pending expectation (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done) begin
         if (q0.size() == 0) begin
            flag_unexpected("dut32_done");
         end else begin
            e = q0.pop_front();
            check("dut32_binary", binary, e.bin);
            check("dut32_error", {31'd0, error}, {31'd0, e.err});
            check("dut32_overflow", {31'd0, overflow}, {31'd0, e.ovf});
            check("dut32_done_cycle", cyc, e.due);
            check("dut32_busy_at_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done16) begin
         if (q1.size() == 0) begin
            flag_unexpected("dut16_done");
         end else begin
            e = q1.pop_front();
            check("dut16_binary", {16'd0, binary16}, e.bin);
            check("dut16_error", {31'd0, error16}, {31'd0, e.err});
            check("dut16_overflow", {31'd0, overflow16}, {31'd0, e.ovf});
            check("dut16_done_cycle", cyc, e.due);
         end
      end
   end

   // Called just after an edge; the following edge accepts the request.
   task automatic start_conv(input bit sel, input logic [31:0] v, input logic neg,
                             input logic [31:0] exp_bin, input logic exp_err,
                             input logic exp_ovf, input int lat);
      exp_t e;
      if (sel) begin
         start16 = 1'b1;
         bcd16   = v;
      end else begin
         start = 1'b1;
         bcd   = v;
      end
`ifdef BCD_SIGN_EN
      bcd_neg   = neg;
      bcd_neg16 = neg;
`else
      if (neg) $display("note: sign request ignored in unsigned build");
`endif
      @(posedge clk);
      #1;
      e.bin = exp_bin;
      e.err = exp_err;
      e.ovf = exp_ovf;
      e.due = cyc + lat;
      if (sel) q1.push_back(e);
      else q0.push_back(e);
      start   = 1'b0;
      start16 = 1'b0;
      bcd     = 32'hFFFF_FFFF;
      bcd16   = 32'hFFFF_FFFF;
   endtask

   task automatic wait_done(input bit sel, input string name);
      for (int i = 0; i < 100; i++) begin
         if ((sel && done16) || (!sel && done)) return;
         @(posedge clk);
         #1;
      end
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout waiting for done", name);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_binary", binary, 32'd0);
      check("reset_error_ovf", {30'd0, error, overflow}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Zero operand.
      start_conv(0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 32);
      wait_done(0, "zero");

      // Ignored start while busy.
      start_conv(0, 32'h1234_5678, 0, 32'h00BC_614E, 0, 0, 32);
      repeat (9) @(posedge clk);
      #1;
      check("busy_mid", {31'd0, busy}, 32'd1);
      start = 1'b1;
      bcd   = 32'h9999_9999;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(0, "12345678");
      @(posedge clk);
      #1;
      check("busy_after", {31'd0, busy}, 32'd0);
      check("binary_held", binary, 32'h00BC_614E);

      // Max operand, then back-to-back start on the done cycle.
      start_conv(0, 32'h9999_9999, 0, 32'h05F5_E0FF, 0, 0, 32);
      wait_done(0, "99999999");
      start_conv(0, 32'h0000_0001, 0, 32'h0000_0001, 0, 0, 32);
      wait_done(0, "b2b_one");

      // Invalid digit, then a valid conversion clears error.
      start_conv(0, 32'h1234_A678, 0, 32'h0000_0000, 1, 0, 0);
      wait_done(0, "invalid");
      start_conv(0, 32'h0000_0042, 0, 32'h0000_002A, 0, 0, 32);
      wait_done(0, "after_invalid");

      // 16-bit result width: 70000 = 0x11170.
      start_conv(1, 32'h0007_0000, 0, 32'h0000_1170, 0, 1, 32);
      wait_done(1, "dut16_70000");
      start_conv(1, 32'h0006_5535, 0, 32'h0000_FFFF, 0, 0, 32);
      wait_done(1, "dut16_65535");

`ifdef BCD_SIGN_EN
      start_conv(0, 32'h0000_0042, 1, 32'hFFFF_FFD6, 0, 0, 33);
      wait_done(0, "neg_42");
      start_conv(0, 32'h0000_0000, 1, 32'h0000_0000, 0, 0, 33);
      wait_done(0, "neg_zero");
      start_conv(0, 32'h0000_0042, 0, 32'h0000_002A, 0, 0, 32);
      wait_done(0, "pos_42");
`endif

      // Reset mid-conversion aborts with no done pulse.
      start_conv(0, 32'h1234_5678, 0, 32'h00BC_614E, 0, 0, 32);
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      q0.delete();
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_binary", binary, 32'd0);
      check("abort_flags", {30'd0, error, overflow}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("abort_idle_busy", {31'd0, busy}, 32'd0);
      check("abort_idle_binary", binary, 32'd0);

      check("q0_drained", q0.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
